// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-port signals around mem_port_arbiter.
// master: the arbiter side. slave: the requesters plus the memory controller FIFOs.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [29:0] i_addr;
  logic [5:0]  i_bl;
  logic        i_rd_valid;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rd_valid;
  logic        d_done;
  logic [31:0] rd_data;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        mem_wr_full;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_empty;

  modport master (
    input  i_req, i_addr, i_bl, d_req, d_we, d_addr, d_wdata,
           mem_cmd_full, mem_wr_full, mem_rd_data, mem_rd_empty,
    output i_rd_valid, i_done, d_rd_valid, d_done, rd_data,
           mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
           mem_wr_en, mem_wr_data, mem_rd_en
  );

  modport slave (
    output i_req, i_addr, i_bl, d_req, d_we, d_addr, d_wdata,
           mem_cmd_full, mem_wr_full, mem_rd_data, mem_rd_empty,
    input  i_rd_valid, i_done, d_rd_valid, d_done, rd_data,
           mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
           mem_wr_en, mem_wr_data, mem_rd_en
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction burst reader and a single-word data port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-first priority.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR, CMD, RD, DONE} state_e;

  state_e      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;   // 1: data requester owns the transaction
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [5:0]  bl_q, bl_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        i_vld_q, i_vld_d;
  logic        d_vld_q, d_vld_d;
  logic        pick_d;

  logic        cmd_en, wr_en, rd_en, i_done, d_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q=0 favours the instruction side; flips to the loser after every grant
  logic        rr_q, rr_d;
  assign pick_d = bus.d_req && (!bus.i_req || rr_q);
`else
  assign pick_d = bus.d_req;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    bl_d      = bl_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    i_vld_d   = 1'b0;
    d_vld_d   = 1'b0;
    cmd_en    = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          gnt_d_d = pick_d;
          we_d    = pick_d && bus.d_we;
          addr_d  = (pick_d ? bus.d_addr : bus.i_addr) & ~30'h3;
          bl_d    = pick_d ? 6'd0 : bus.i_bl;
          wdata_d = bus.d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d    = !pick_d;
`endif
          state_d = (pick_d && bus.d_we) ? WR : CMD;
        end
      end
      WR: begin
        wr_en = !bus.mem_wr_full;
        if (!bus.mem_wr_full) state_d = CMD;
      end
      CMD: begin
        cmd_en = !bus.mem_cmd_full;
        if (!bus.mem_cmd_full) begin
          cnt_d   = bl_q;
          state_d = we_q ? DONE : RD;
        end
      end
      RD: begin
        rd_en = !bus.mem_rd_empty;
        if (!bus.mem_rd_empty) begin
          rd_data_d = bus.mem_rd_data;
          i_vld_d   = !gnt_d_q;
          d_vld_d   = gnt_d_q;
          if (cnt_q == 6'd0) state_d = DONE;
          else               cnt_d   = cnt_q - 6'd1;
        end
      end
      DONE: begin
        i_done  = !gnt_d_q;
        d_done  = gnt_d_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      bl_q      <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      i_vld_q   <= 1'b0;
      d_vld_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      bl_q      <= bl_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      i_vld_q   <= i_vld_d;
      d_vld_q   <= d_vld_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign bus.i_rd_valid        = i_vld_q;
  assign bus.d_rd_valid        = d_vld_q;
  assign bus.i_done            = i_done;
  assign bus.d_done            = d_done;
  assign bus.rd_data           = rd_data_q;
  assign bus.mem_cmd_en        = cmd_en;
  assign bus.mem_cmd_instr     = we_q ? 3'b000 : 3'b001;
  assign bus.mem_cmd_bl        = bl_q;
  assign bus.mem_cmd_byte_addr = addr_q;
  assign bus.mem_wr_en         = wr_en;
  assign bus.mem_wr_data       = wdata_q;
  assign bus.mem_rd_en         = rd_en;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives inputs and samples outputs 1ns after each
// rising edge; a monitor logs memory-port and requester events at the rising edge.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // read-data FIFO model: rd_wp moved by the stimulus, rd_rp by the monitor
  logic [31:0] rd_mem [0:15];
  int rd_wp = 0;
  int rd_rp = 0;
  assign bus.mem_rd_empty = (rd_rp == rd_wp);
  assign bus.mem_rd_data  = rd_mem[rd_rp[3:0]];

  int n_cmd = 0, n_wr = 0, n_pop = 0, n_idone = 0, n_ddone = 0, viol = 0;
  logic [2:0]  last_instr;
  logic [5:0]  last_bl;
  logic [29:0] last_addr;
  logic [31:0] last_wdata;
  logic [31:0] i_words[$];
  logic [31:0] d_words[$];
  bit          order[$];   // 0: instruction done, 1: data done

  always @(posedge clk) begin
    if (bus.mem_cmd_en) begin
      n_cmd++; last_instr = bus.mem_cmd_instr; last_bl = bus.mem_cmd_bl;
      last_addr = bus.mem_cmd_byte_addr;
    end
    if (bus.mem_wr_en) begin n_wr++; last_wdata = bus.mem_wr_data; end
    if (bus.mem_rd_en) begin n_pop++; rd_rp <= rd_rp + 1; end
    if (bus.i_rd_valid) i_words.push_back(bus.rd_data);
    if (bus.d_rd_valid) d_words.push_back(bus.rd_data);
    if (bus.i_done) begin n_idone++; order.push_back(1'b0); end
    if (bus.d_done) begin n_ddone++; order.push_back(1'b1); end
    if ((bus.mem_rd_en && bus.mem_rd_empty) || (bus.mem_wr_en && bus.mem_wr_full) ||
        (bus.mem_cmd_en && bus.mem_cmd_full) || (bus.i_done && bus.d_done)) viol++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // requesters release their req after seeing their done pulse
  task automatic step();
    int pi = n_idone;
    int pd = n_ddone;
    @(posedge clk); #1;
    if (n_idone != pi) bus.i_req = 1'b0;
    if (n_ddone != pd) bus.d_req = 1'b0;
  endtask

  task automatic run_until(input int cnt, input int budget, input string tag);
    int tgt = n_idone + n_ddone + cnt;
    int k = 0;
    while ((n_idone + n_ddone) < tgt && k < budget) begin step(); k++; end
    chk({tag, "_timeout"}, 64'((n_idone + n_ddone) >= tgt), 64'd1);
  endtask

  task automatic push_word(input logic [31:0] w);
    rd_mem[rd_wp[3:0]] = w;
    rd_wp++;
  endtask

  function automatic logic [6:0] outs();
    return {bus.i_rd_valid, bus.i_done, bus.d_rd_valid, bus.d_done,
            bus.mem_cmd_en, bus.mem_wr_en, bus.mem_rd_en};
  endfunction

  int b_cmd, b_wr, b_pop, b_id, b_dd, b_iw, b_dw, b_or, k;
  task automatic mark();
    b_cmd = n_cmd; b_wr = n_wr; b_pop = n_pop; b_id = n_idone; b_dd = n_ddone;
    b_iw = i_words.size(); b_dw = d_words.size(); b_or = order.size();
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.i_bl = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_cmd_full = 0; bus.mem_wr_full = 0;

    // reset state
    repeat (3) step();
    chk("rst_outs", 64'(outs()), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    rst_n = 1'b1;
    step();

    // 4-word instruction burst
    mark();
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    bus.i_addr = 30'h100; bus.i_bl = 6'd3; bus.i_req = 1'b1;
    run_until(1, 40, "burst");
    chk("burst_ncmd", 64'(n_cmd - b_cmd), 64'd1);
    chk("burst_instr", 64'(last_instr), 64'd1);
    chk("burst_bl", 64'(last_bl), 64'd3);
    chk("burst_addr", 64'(last_addr), 64'h100);
    chk("burst_nvalid", 64'(i_words.size() - b_iw), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i_words.size() > b_iw + i)
        chk($sformatf("burst_word%0d", i), 64'(i_words[b_iw + i]), 64'(32'hA000_0000 + 32'(i)));
    chk("burst_dvalid", 64'(d_words.size() - b_dw), 64'd0);
    step(); step();
    chk("burst_idone", 64'(n_idone - b_id), 64'd1);

    // data write with write FIFO full for 3 cycles
    mark();
    bus.mem_wr_full = 1'b1;
    bus.d_we = 1'b1; bus.d_addr = 30'h203; bus.d_wdata = 32'hDEADBEEF; bus.d_req = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wr_hold%0d", i), 64'(bus.mem_wr_en), 64'd0);
      if (i < 2) step();
    end
    step();
    chk("wr_nopush_while_full", 64'(n_wr - b_wr), 64'd0);
    bus.mem_wr_full = 1'b0;
    step();
    chk("wr_push", 64'(n_wr - b_wr), 64'd1);
    chk("wr_wdata", 64'(last_wdata), 64'hDEADBEEF);
    run_until(1, 20, "wr");
    chk("wr_instr", 64'(last_instr), 64'd0);
    chk("wr_addr", 64'(last_addr), 64'h200);
    chk("wr_bl", 64'(last_bl), 64'd0);
    chk("wr_ddone", 64'(n_ddone - b_dd), 64'd1);
    chk("wr_ncmd", 64'(n_cmd - b_cmd), 64'd1);
    bus.d_we = 1'b0;
    step();

    // command FIFO full for 4 cycles in CMD
    mark();
    bus.mem_cmd_full = 1'b1;
    push_word(32'h0000_00C1);
    bus.i_addr = 30'h40; bus.i_bl = 6'd0; bus.i_req = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cmd_hold%0d", i), 64'(bus.mem_cmd_en), 64'd0);
      step();
    end
    chk("cmd_none_while_full", 64'(n_cmd - b_cmd), 64'd0);
    bus.mem_cmd_full = 1'b0;
    step();
    chk("cmd_issued", 64'(n_cmd - b_cmd), 64'd1);
    chk("cmd_one_cycle", 64'(bus.mem_cmd_en), 64'd0);
    run_until(1, 20, "cmd");
    chk("cmd_once", 64'(n_cmd - b_cmd), 64'd1);
    chk("cmd_addr", 64'(last_addr), 64'h40);
    if (i_words.size() > b_iw) chk("cmd_word", 64'(i_words[b_iw]), 64'hC1);
    else chk("cmd_word_seen", 64'd0, 64'd1);
    step();

    // two-word burst with read FIFO empty for 5 cycles between words
    mark();
    push_word(32'h1111_0001);
    bus.i_addr = 30'h80; bus.i_bl = 6'd1; bus.i_req = 1'b1;
    k = 0;
    while (i_words.size() - b_iw < 1 && k < 20) begin step(); k++; end
    chk("stall_first_word", 64'(i_words.size() - b_iw), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_cyc%0d", i), 64'({bus.mem_rd_en, bus.i_rd_valid, bus.i_done}), 64'd0);
      step();
    end
    push_word(32'h1111_0002);
    run_until(1, 20, "stall");
    chk("stall_nvalid", 64'(i_words.size() - b_iw), 64'd2);
    if (i_words.size() >= b_iw + 2)
      chk("stall_word2", 64'(i_words[b_iw + 1]), 64'h1111_0002);
    chk("stall_npop", 64'(n_pop - b_pop), 64'd2);
    chk("stall_idone", 64'(n_idone - b_id), 64'd1);
    step();

    // reset in the middle of an 8-word burst
    mark();
    for (int i = 0; i < 8; i++) push_word(32'hB000_0000 + 32'(i));
    bus.i_addr = 30'h300; bus.i_bl = 6'd7; bus.i_req = 1'b1;
    k = 0;
    while (n_pop - b_pop < 2 && k < 20) begin step(); k++; end
    chk("abort_two_pops", 64'(n_pop - b_pop), 64'd2);
    rst_n = 1'b0; bus.i_req = 1'b0;
    step();
    chk("abort_outs", 64'(outs()), 64'd0);
    chk("abort_rd_data", 64'(bus.rd_data), 64'd0);
    chk("abort_nvalid", 64'(i_words.size() - b_iw), 64'd2);
    rst_n = 1'b1;
    rd_wp = rd_rp;
    repeat (4) step();
    chk("abort_no_done", 64'(n_idone - b_id), 64'd0);
    chk("abort_idle_outs", 64'(outs()), 64'd0);

    // simultaneous requests right after reset
    mark();
    push_word(32'h0000_00E0);
    push_word(32'h0000_00E1);
    bus.i_addr = 30'h10; bus.i_bl = 6'd0;
    bus.d_we = 1'b0; bus.d_addr = 30'h20;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    run_until(2, 60, "arb");
    if (order.size() >= b_or + 2) begin
      chk("arb_first", 64'(order[b_or]), 64'(!RR));
      chk("arb_second", 64'(order[b_or + 1]), 64'(RR));
    end else chk("arb_two_dones", 64'(order.size() - b_or), 64'd2);
    if (i_words.size() > b_iw && d_words.size() > b_dw) begin
      chk("arb_iword", 64'(i_words[b_iw]), RR ? 64'hE0 : 64'hE1);
      chk("arb_dword", 64'(d_words[b_dw]), RR ? 64'hE1 : 64'hE0);
    end else chk("arb_words_seen", 64'd0, 64'd1);
    chk("arb_last_addr", 64'(last_addr), RR ? 64'h20 : 64'h10);
    step();

    chk("port_rules", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
